// File: rtl/keypad_scan_onehot.sv
// 4x4 matrix keypad scanner with debounce; presents the last confirmed key as a
// registered one-hot code plus its binary index, a press strobe and a held flag.
module keypad_scan_onehot #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] onehot,
  output logic [3:0]  key_code,
  output logic        key_pulse,
  output logic        key_down
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_s1_q, row_s2_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_lat_q, row_lat_d;
  logic [15:0]       onehot_q, onehot_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_pulse_q, key_pulse_d;
  logic              key_down_q, key_down_d;

  logic              tick;
  logic              any_low;
  logic [1:0]        row_sel;
  logic [3:0]        cnt_inc;
  logic [3:0]        key_idx;

  assign tick    = (div_q == DivW'(SCAN_DIV - 1));
  assign any_low = ~&row_s2_q;
  assign cnt_inc = cnt_q + 4'd1;
  assign key_idx = {row_lat_q, col_q};

  // Lowest-indexed low row wins when several rows are pulled down together.
  always_comb begin
    if (!row_s2_q[0])      row_sel = 2'd0;
    else if (!row_s2_q[1]) row_sel = 2'd1;
    else if (!row_s2_q[2]) row_sel = 2'd2;
    else                   row_sel = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_lat_d   = row_lat_q;
    onehot_d    = onehot_q;
    key_code_d  = key_code_q;
    key_pulse_d = 1'b0;
    key_down_d  = key_down_q;
    div_d       = tick ? '0 : div_q + 1'b1;

    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (!any_low) begin
            col_d = col_q + 2'd1;
          end else begin
            row_lat_d = row_sel;
            cnt_d     = 4'd1;
            state_d   = StDebounce;
          end
        end
        StDebounce: begin
          if (any_low && (row_sel == row_lat_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE)) begin
              state_d     = StHeld;
              cnt_d       = 4'd0;
              onehot_d    = 16'd1 << key_idx;
              key_code_d  = key_idx;
              key_pulse_d = 1'b1;
              key_down_d  = 1'b1;
            end
          end else begin
            state_d = StScan;
            col_d   = col_q + 2'd1;
          end
        end
        StHeld: begin
          // Column stays frozen; any bounce restarts the release count.
          if (any_low) begin
            cnt_d = 4'd0;
          end else if (cnt_inc == 4'(DEBOUNCE)) begin
            cnt_d      = 4'd0;
            key_down_d = 1'b0;
            col_d      = col_q + 2'd1;
            state_d    = StScan;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StScan;
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_q       <= '0;
      cnt_q       <= 4'd0;
      col_q       <= 2'd0;
      row_lat_q   <= 2'd0;
      onehot_q    <= 16'h0000;
      key_code_q  <= 4'd0;
      key_pulse_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_lat_q   <= row_lat_d;
      onehot_q    <= onehot_d;
      key_code_q  <= key_code_d;
      key_pulse_q <= key_pulse_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign onehot    = onehot_q;
  assign key_code  = key_code_q;
  assign key_pulse = key_pulse_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_onehot.sv
// Scoreboarded bench: a keypad model drives rows, expected key codes are queued
// when a press is long enough to confirm, and a monitor checks every key_pulse.
module tb_keypad_scan_onehot;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic [3:0]  key_code;
  logic        key_pulse;
  logic        key_down;

  logic [15:0] pressed = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  int          exp_q[$];

  keypad_scan_onehot #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .onehot    (onehot),
    .key_code  (key_code),
    .key_pulse (key_pulse),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key shorts its row to its column when that column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expected key.
  always @(negedge clk) begin
    if (!rst && key_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got code %0d expected no pulse", key_code);
      end else begin
        int k;
        k = exp_q.pop_front();
        chk("pulse_code", {28'd0, key_code}, k);
        chk("pulse_onehot", {16'd0, onehot}, 32'd1 << k);
        chk("pulse_down", {31'd0, key_down}, 1);
      end
    end
  end

  task automatic wait_level(input string name, input logic want);
    int n = 0;
    while (key_down !== want && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (key_down !== want) begin
      checks++;
      failures++;
      $display("FAIL %s: key_down timeout got %0b expected %0b", name, key_down, want);
    end
  endtask

  initial begin
    logic [3:0] c;
    int n;
    int k;
    int len;

    // Reset held
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, col_out}, 4'b1110);
    chk("rst_onehot", {16'd0, onehot}, 0);
    chk("rst_code", {28'd0, key_code}, 0);
    chk("rst_pulse", {31'd0, key_pulse}, 0);
    chk("rst_down", {31'd0, key_down}, 0);
    rst = 1'b0;

    // Idle scan: one column step per slot
    for (int i = 0; i < 8; i++) begin
      c = ~(4'b0001 << (i % 4));
      chk("idle_col", {28'd0, col_out}, c);
      repeat (SD) @(negedge clk);
    end
    chk("idle_onehot", {16'd0, onehot}, 0);

    // Row1/col2 press held
    pressed = 16'h0040;
    exp_q.push_back(6);
    wait_level("press6", 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("held_col", {28'd0, col_out}, 4'b1011);
      repeat (SD) @(negedge clk);
    end
    chk("held_down", {31'd0, key_down}, 1);

    // Release timing: third all-high tick lands 11..14 edges after release
    pressed = 16'h0000;
    n = 0;
    while (key_down && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("release_window", {31'd0, (n >= 11 && n <= 14)}, 1);
    chk("release_col", {28'd0, col_out}, 4'b0111);
    chk("release_onehot", {16'd0, onehot}, 16'h0040);

    // Row0/col0 seen for exactly two ticks: aborted
    n = 0;
    while (col_out == 4'b1110 && n < 50) begin @(negedge clk); n++; end
    while (col_out != 4'b1110 && n < 50) begin @(negedge clk); n++; end
    chk("short_sync", {31'd0, (n < 50)}, 1);
    pressed = 16'h0001;
    repeat (2 * SD) @(negedge clk);
    pressed = 16'h0000;
    repeat (10 * SD) @(negedge clk);
    chk("short_onehot", {16'd0, onehot}, 16'h0040);
    chk("short_down", {31'd0, key_down}, 0);
    c = col_out;
    repeat (SD) @(negedge clk);
    chk("short_scan", {28'd0, col_out}, {c[2:0], c[3]});

    // Rows 2 and 3 in col3: row2 wins
    pressed = 16'h8800;
    exp_q.push_back(11);
    wait_level("press11", 1'b1);
    chk("ghost_onehot", {16'd0, onehot}, 16'h0800);
    chk("ghost_code", {28'd0, key_code}, 11);
    pressed = 16'h0000;
    wait_level("release11", 1'b0);

    // Reset during HELD with row3/col1 pressed
    pressed = 16'h2000;
    exp_q.push_back(13);
    wait_level("press13", 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_col", {28'd0, col_out}, 4'b1110);
    chk("arst_onehot", {16'd0, onehot}, 0);
    chk("arst_code", {28'd0, key_code}, 0);
    chk("arst_down", {31'd0, key_down}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(13);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (key_pulse) n++;
    end
    chk("no_pulse_on_release", n, 0);
    wait_level("repress13", 1'b1);
    chk("repress_onehot", {16'd0, onehot}, 16'h2000);
    pressed = 16'h0000;
    wait_level("release13", 1'b0);

    // Random single-key presses: long ones must confirm, short ones never can
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(15);
      if ($urandom_range(1) == 1) begin
        exp_q.push_back(k);
        pressed = 16'd1 << k;
        repeat ((4 + DB + 2) * SD) @(negedge clk);
        chk("rand_down_hi", {31'd0, key_down}, 1);
        chk("rand_onehot", {16'd0, onehot}, 32'd1 << k);
      end else begin
        len = $urandom_range((DB - 1) * SD - 1, 1);
        pressed = 16'd1 << k;
        repeat (len) @(negedge clk);
      end
      pressed = 16'h0000;
      repeat ((DB + 3) * SD) @(negedge clk);
      chk("rand_down_lo", {31'd0, key_down}, 0);
    end

    repeat (4 * SD) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
